data_memory_arbiter: RTL

- Shares the single-port data memory between the MIPS MEM stage (CPU port) and a debug dump sequencer that streams a block of memory words to the debug unit (UART side).
- The CPU always has priority. The dump engine steals only idle memory cycles, so pipeline timing is never altered in the default build.
- Sits between the MEM stage, the debug unit and data_memory. It drives all data_memory inputs except the clock.

---
 rtl/data_memory_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/data_memory_arbiter.sv
// rtl/data_memory_arbiter.sv - CPU-priority data memory arbiter with debug dump sequencer
// Optional starvation guard: define DMEM_ARB_STARVE_GUARD_EN.
module data_memory_arbiter #(
    parameter int NB_DATA      = 32,
    parameter int RAM_DEPTH    = 256,
    parameter int NB_ADDR      = 8,
    parameter int STARVE_LIMIT = 16
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_cpu_address,
    input  logic [NB_DATA-1:0] i_cpu_write_data,
    input  logic               i_cpu_read_enable,
    input  logic               i_cpu_write_enable,
    input  logic               i_cpu_valid,
    output logic [NB_DATA-1:0] o_cpu_read_data,
    output logic               o_cpu_stall,
    input  logic               i_dump_start,
    input  logic [NB_ADDR-1:0] i_dump_base,
    input  logic [NB_ADDR:0]   i_dump_count,
    output logic [NB_DATA-1:0] o_dump_data,
    output logic               o_dump_valid,
    input  logic               i_dump_ready,
    output logic               o_dump_busy,
    output logic               o_dump_done,
    output logic [NB_DATA-1:0] o_mem_address,
    output logic [NB_DATA-1:0] o_mem_write_data,
    output logic               o_mem_read_enable,
    output logic               o_mem_write_enable,
    output logic               o_mem_valid,
    input  logic [NB_DATA-1:0] i_mem_read_data
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Address wrap relies on the natural overflow of the NB_ADDR-bit counter.
    if (RAM_DEPTH != (1 << NB_ADDR) || STARVE_LIMIT < 1) begin : g_param_check
        $error("data_memory_arbiter: RAM_DEPTH must be 2**NB_ADDR and STARVE_LIMIT >= 1");
    end

    state_t             r_state;
    logic [NB_ADDR-1:0] r_addr;
    logic [NB_ADDR:0]   r_remaining;
    logic [NB_DATA-1:0] r_dump_data;
    logic               r_dump_valid;
    logic               r_dump_done;

    logic w_cpu_req;
    logic w_force;
    logic w_cpu_grant;

    assign w_cpu_req   = i_cpu_valid & (i_cpu_read_enable | i_cpu_write_enable);
    assign w_cpu_grant = w_cpu_req & ~w_force;

`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam int NB_STARVE = $clog2(STARVE_LIMIT + 1);
    logic [NB_STARVE-1:0] r_starve;

    assign w_force     = (r_state == ST_FETCH) && (r_starve == NB_STARVE'(STARVE_LIMIT));
    assign o_cpu_stall = w_force;

    // Counts only FETCH cycles lost to the CPU; any other cycle restarts it.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_starve <= '0;
        end else if (r_state == ST_FETCH && w_cpu_req && !w_force) begin
            r_starve <= r_starve + 1'b1;
        end else begin
            r_starve <= '0;
        end
    end
`else
    assign w_force     = 1'b0;
    assign o_cpu_stall = 1'b0;
`endif

    always_comb begin
        o_mem_address      = '0;
        o_mem_write_data   = '0;
        o_mem_read_enable  = 1'b0;
        o_mem_write_enable = 1'b0;
        o_mem_valid        = 1'b0;
        o_cpu_read_data    = '0;
        if (w_cpu_grant) begin
            o_mem_address      = i_cpu_address;
            o_mem_write_data   = i_cpu_write_data;
            o_mem_read_enable  = i_cpu_read_enable;
            o_mem_write_enable = i_cpu_write_enable;
            o_mem_valid        = i_cpu_valid;
            o_cpu_read_data    = i_mem_read_data;
        end else if (r_state == ST_FETCH) begin
            o_mem_address     = {{(NB_DATA-NB_ADDR){1'b0}}, r_addr};
            o_mem_read_enable = 1'b1;
            o_mem_valid       = 1'b1;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_remaining  <= '0;
            r_dump_data  <= '0;
            r_dump_valid <= 1'b0;
            r_dump_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_dump_done <= 1'b0;
                    if (i_dump_start) begin
                        r_addr      <= i_dump_base;
                        r_remaining <= i_dump_count;
                        if (i_dump_count == '0) begin
                            r_state     <= ST_DONE;
                            r_dump_done <= 1'b1;
                        end else begin
                            r_state <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    if (!w_cpu_grant) begin
                        r_dump_data  <= i_mem_read_data;
                        r_dump_valid <= 1'b1;
                        r_state      <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (i_dump_ready) begin
                        r_dump_valid <= 1'b0;
                        r_remaining  <= r_remaining - 1'b1;
                        if (r_remaining == {{NB_ADDR{1'b0}}, 1'b1}) begin
                            r_state     <= ST_DONE;
                            r_dump_done <= 1'b1;
                        end else begin
                            r_addr  <= r_addr + 1'b1;
                            r_state <= ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    r_dump_done <= 1'b0;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_dump_data  = r_dump_data;
    assign o_dump_valid = r_dump_valid;
    assign o_dump_done  = r_dump_done;
    assign o_dump_busy  = (r_state != ST_IDLE);

endmodule
